// File: rtl/aq_fifo_pkt_sync.sv
// Single-clock FIFO with optional store-and-forward packet mode.
// Words become readable at commit_ptr; wr_ptr runs ahead speculatively inside a packet.
module aq_fifo_pkt_sync #(
  parameter int FIFO_DEPTH = 9,
  parameter int FIFO_WIDTH = 64,
  parameter int PKT_MODE   = 1
) (
  input  logic                  FIFO_CLK,
  input  logic                  RST_N,
  input  logic                  FIFO_WR_ENA,
  input  logic [FIFO_WIDTH-1:0] FIFO_WR_DATA,
  input  logic                  FIFO_WR_LAST,
  input  logic                  FIFO_WR_DROP,
  output logic                  FIFO_WR_FULL,
  output logic                  FIFO_WR_ALM_FULL,
  input  logic [FIFO_DEPTH:0]   FIFO_WR_ALM_COUNT,
  output logic                  FIFO_WR_OVERFLOW,
  input  logic                  FIFO_RD_ENA,
  output logic [FIFO_WIDTH-1:0] FIFO_RD_DATA,
  output logic                  FIFO_RD_LAST,
  output logic                  FIFO_RD_VALID,
  output logic                  FIFO_RD_EMPTY,
  output logic                  FIFO_RD_ALM_EMPTY,
  input  logic [FIFO_DEPTH:0]   FIFO_RD_ALM_COUNT,
  output logic                  FIFO_RD_UNDERFLOW,
  output logic [FIFO_DEPTH:0]   FIFO_PKT_COUNT
);
  localparam logic [FIFO_DEPTH:0] LP_FULL = {1'b1, {FIFO_DEPTH{1'b0}}};

  logic [FIFO_WIDTH:0]   r_mem [0:(1<<FIFO_DEPTH)-1];
  logic [FIFO_DEPTH:0]   r_wr_ptr, r_commit_ptr, r_rd_ptr, r_pkt_count;
  logic [FIFO_WIDTH-1:0] r_rd_data;
  logic                  r_rd_last, r_rd_valid, r_ovf, r_unf, r_bad;

  logic [FIFO_DEPTH:0]   w_wr_used, w_rd_used;
  logic [FIFO_WIDTH:0]   w_rd_word;
  logic                  w_full, w_empty, w_drop, w_wr_acc, w_rd_acc, w_inc, w_dec;

  assign w_wr_used = r_wr_ptr - r_rd_ptr;
  assign w_rd_used = r_commit_ptr - r_rd_ptr;
  assign w_full    = (w_wr_used == LP_FULL);
  assign w_empty   = (r_commit_ptr == r_rd_ptr);
  assign w_drop    = (PKT_MODE != 0) && FIFO_WR_DROP;
  assign w_wr_acc  = FIFO_WR_ENA & ~w_full & ~w_drop & ~r_bad;
  assign w_rd_acc  = FIFO_RD_ENA & ~w_empty;
  assign w_rd_word = r_mem[r_rd_ptr[FIFO_DEPTH-1:0]];
  assign w_inc     = w_wr_acc & FIFO_WR_LAST;
  assign w_dec     = w_rd_acc & w_rd_word[FIFO_WIDTH];

  assign FIFO_WR_FULL      = w_full;
  assign FIFO_WR_ALM_FULL  = (w_wr_used >= FIFO_WR_ALM_COUNT);
  assign FIFO_WR_OVERFLOW  = r_ovf;
  assign FIFO_RD_DATA      = r_rd_data;
  assign FIFO_RD_LAST      = r_rd_last;
  assign FIFO_RD_VALID     = r_rd_valid;
  assign FIFO_RD_EMPTY     = w_empty;
  assign FIFO_RD_ALM_EMPTY = (w_rd_used <= FIFO_RD_ALM_COUNT);
  assign FIFO_RD_UNDERFLOW = r_unf;
  assign FIFO_PKT_COUNT    = r_pkt_count;

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge FIFO_CLK) begin
    if (w_wr_acc) r_mem[r_wr_ptr[FIFO_DEPTH-1:0]] <= {FIFO_WR_LAST, FIFO_WR_DATA};
  end

  always_ff @(posedge FIFO_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_pkt_count  <= '0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
      r_bad        <= 1'b0;
    end else begin
      r_ovf <= FIFO_WR_ENA & w_full;
      r_unf <= FIFO_RD_ENA & w_empty;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop) begin
        r_wr_ptr <= r_commit_ptr;
      end else if (r_bad) begin
        // Corrupt packet: swallow words until its LAST, then rewind.
        if (FIFO_WR_ENA & FIFO_WR_LAST) begin
          r_wr_ptr <= r_commit_ptr;
          r_bad    <= 1'b0;
        end
      end else if (FIFO_WR_ENA & w_full) begin
        if (PKT_MODE != 0) begin
          if (FIFO_WR_LAST) r_wr_ptr <= r_commit_ptr;
          else              r_bad    <= 1'b1;
        end
      end else if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if ((PKT_MODE == 0) || FIFO_WR_LAST) r_commit_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_inc & ~w_dec)      r_pkt_count <= r_pkt_count + 1'b1;
      else if (~w_inc & w_dec) r_pkt_count <= r_pkt_count - 1'b1;
    end
  end

  always_ff @(posedge FIFO_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rd_data  <= '0;
      r_rd_last  <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= w_rd_word[FIFO_WIDTH-1:0];
        r_rd_last <= w_rd_word[FIFO_WIDTH];
      end
    end
  end
endmodule
